// File: rtl/tx_config.sv
// Purpose: write-back instruction decoder; configures obuf drain, issues DDR write command(s), counts beats, reports done.
// Latency: accept -> conf/cmd valid next cycle; done pulse the cycle after the final beat; ready again the cycle after the pulse.
// Backpressure: one instruction in flight; conf and cmd valids each held until their own handshake; option TX_BURST_SPLIT_EN splits into MAX_BURST-beat commands.
module tx_config #(
    parameter int PE_NUM     = 32,
    parameter int INST_W     = 64,
    parameter int BEAT_BYTES = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        layer_type,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [INST_W-1:0] ins,
    output logic              obuf_conf_valid,
    input  logic              obuf_conf_ready,
    output logic [3:0]        obuf_conf_mode,
    output logic [15:0]       obuf_conf_trans_num,
    output logic [PE_NUM-1:0] obuf_conf_mask,
    output logic              ddr_cmd_valid,
    input  logic              ddr_cmd_ready,
    output logic [31:0]       ddr_cmd_addr,
    output logic [15:0]       ddr_cmd_len,
    input  logic              beat_valid,
    input  logic              beat_ready,
    output logic              tx_done_pulse,
    output logic [3:0]        tx_done_opcode,
    output logic [5:0]        tx_done_buf_id,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CONF, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [5:0]        buf_id_q, buf_id_d;
    logic [11:0]       p_size_q, p_size_d;
    logic [31:0]       addr_q, addr_d;
    logic [15:0]       len_q, len_d;
    logic [PE_NUM-1:0] mask_q, mask_d;
    logic [3:0]        mode_q, mode_d;
    logic [11:0]       cnt_q, cnt_d;
    logic              conf_vld_q, conf_vld_d;
    logic              cmd_vld_q, cmd_vld_d;
    logic [3:0]        done_opcode_q, done_opcode_d;
    logic [5:0]        done_buf_id_q, done_buf_id_d;

    // Instruction field decode
    logic [3:0]        in_opcode;
    logic [5:0]        in_buf_id;
    logic [11:0]       in_p_size;
    logic [31:0]       in_addr;
    logic [7:0]        nib_shift;
    logic [PE_NUM-1:0] in_mask;
    logic [15:0]       first_len;
    logic              unused_ins_bits;

    assign in_opcode = ins[61:58];
    assign in_buf_id = ins[57:52];
    assign in_p_size = ins[51:40];
    assign in_addr   = ins[31:0];
    assign nib_shift = {in_buf_id, 2'b00};
    // Shifts past PE_NUM fall off the top, giving the required truncation.
    assign in_mask   = layer_type[0] ? (PE_NUM'(1) << in_buf_id) : (PE_NUM'(4'hF) << nib_shift);
    assign unused_ins_bits = ^{ins[INST_W-1:62], ins[39:32]};

`ifdef TX_BURST_SPLIT_EN
    localparam logic [11:0] MAX_LEN = 12'(MAX_BURST);

    // Beat index at which the currently issued command ends.
    logic [11:0] burst_end_q, burst_end_d;
    logic [11:0] next_len;

    function automatic logic [11:0] burst_len(input logic [11:0] rem);
        return (rem > MAX_LEN) ? MAX_LEN : rem;
    endfunction

    assign first_len = {4'b0, burst_len(in_p_size)};
    assign next_len  = burst_len(p_size_q - burst_end_q);
`else
    assign first_len = {4'b0, in_p_size};
`endif

    // Next-state, capture and handshake bookkeeping
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        buf_id_d      = buf_id_q;
        p_size_d      = p_size_q;
        addr_d        = addr_q;
        len_d         = len_q;
        mask_d        = mask_q;
        mode_d        = mode_q;
        cnt_d         = cnt_q;
        conf_vld_d    = conf_vld_q;
        cmd_vld_d     = cmd_vld_q;
        done_opcode_d = done_opcode_q;
        done_buf_id_d = done_buf_id_q;
`ifdef TX_BURST_SPLIT_EN
        burst_end_d   = burst_end_q;
`endif
        case (state_q)
            IDLE: begin
                if (ins_valid) begin
                    opcode_d = in_opcode;
                    buf_id_d = in_buf_id;
                    p_size_d = in_p_size;
                    addr_d   = in_addr;
                    len_d    = first_len;
                    mask_d   = in_mask;
                    mode_d   = layer_type;
                    cnt_d    = '0;
`ifdef TX_BURST_SPLIT_EN
                    burst_end_d = first_len[11:0];
`endif
                    if (in_p_size == 12'd0) begin
                        state_d       = DONE;
                        done_opcode_d = in_opcode;
                        done_buf_id_d = in_buf_id;
                    end else begin
                        state_d    = CONF;
                        conf_vld_d = 1'b1;
                        cmd_vld_d  = 1'b1;
                    end
                end
            end
            CONF: begin
                if (obuf_conf_ready) conf_vld_d = 1'b0;
                if (ddr_cmd_ready)   cmd_vld_d  = 1'b0;
                if ((!conf_vld_q || obuf_conf_ready) && (!cmd_vld_q || ddr_cmd_ready))
                    state_d = XFER;
            end
            XFER: begin
                if (ddr_cmd_ready) cmd_vld_d = 1'b0;
                if (beat_valid && beat_ready) begin
                    cnt_d = cnt_q + 12'd1;
                    if (cnt_d == p_size_q) begin
                        state_d       = DONE;
                        done_opcode_d = opcode_q;
                        done_buf_id_d = buf_id_q;
                    end
`ifdef TX_BURST_SPLIT_EN
                    else if (cnt_d == burst_end_q) begin
                        cmd_vld_d   = 1'b1;
                        addr_d      = addr_q + 32'(len_q) * 32'(BEAT_BYTES);
                        len_d       = {4'b0, next_len};
                        burst_end_d = burst_end_q + next_len;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            opcode_q      <= '0;
            buf_id_q      <= '0;
            p_size_q      <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            mask_q        <= '0;
            mode_q        <= '0;
            cnt_q         <= '0;
            conf_vld_q    <= 1'b0;
            cmd_vld_q     <= 1'b0;
            done_opcode_q <= '0;
            done_buf_id_q <= '0;
`ifdef TX_BURST_SPLIT_EN
            burst_end_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            buf_id_q      <= buf_id_d;
            p_size_q      <= p_size_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            mask_q        <= mask_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            conf_vld_q    <= conf_vld_d;
            cmd_vld_q     <= cmd_vld_d;
            done_opcode_q <= done_opcode_d;
            done_buf_id_q <= done_buf_id_d;
`ifdef TX_BURST_SPLIT_EN
            burst_end_q   <= burst_end_d;
`endif
        end
    end

    assign ins_ready           = (state_q == IDLE);
    assign busy                = (state_q != IDLE);
    assign obuf_conf_valid     = conf_vld_q;
    assign obuf_conf_mode      = mode_q;
    assign obuf_conf_trans_num = {4'b0, p_size_q};
    assign obuf_conf_mask      = mask_q;
    assign ddr_cmd_valid       = cmd_vld_q;
    assign ddr_cmd_addr        = addr_q;
    assign ddr_cmd_len         = len_q;
    assign tx_done_pulse       = (state_q == DONE);
    assign tx_done_opcode      = done_opcode_q;
    assign tx_done_buf_id      = done_buf_id_q;

endmodule

// File: tb/tb_tx_config.sv
module tb_tx_config;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  layer_type = '0;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [63:0] ins = '0;
    logic        obuf_conf_valid;
    logic        obuf_conf_ready = 1'b1;
    logic [3:0]  obuf_conf_mode;
    logic [15:0] obuf_conf_trans_num;
    logic [31:0] obuf_conf_mask;
    logic        ddr_cmd_valid;
    logic        ddr_cmd_ready = 1'b1;
    logic [31:0] ddr_cmd_addr;
    logic [15:0] ddr_cmd_len;
    logic        beat_valid = 1'b0;
    logic        beat_ready = 1'b0;
    logic        tx_done_pulse;
    logic [3:0]  tx_done_opcode;
    logic [5:0]  tx_done_buf_id;
    logic        busy;

    always #5 clk = ~clk;

    tx_config dut (
        .clk(clk), .rst_n(rst_n), .layer_type(layer_type),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
        .obuf_conf_valid(obuf_conf_valid), .obuf_conf_ready(obuf_conf_ready),
        .obuf_conf_mode(obuf_conf_mode), .obuf_conf_trans_num(obuf_conf_trans_num),
        .obuf_conf_mask(obuf_conf_mask),
        .ddr_cmd_valid(ddr_cmd_valid), .ddr_cmd_ready(ddr_cmd_ready),
        .ddr_cmd_addr(ddr_cmd_addr), .ddr_cmd_len(ddr_cmd_len),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .tx_done_pulse(tx_done_pulse), .tx_done_opcode(tx_done_opcode),
        .tx_done_buf_id(tx_done_buf_id), .busy(busy)
    );

    int vectors = 0;
    int errors  = 0;

    // Expected {mode, trans_num, mask}, {addr, len}, {opcode, buf_id}
    logic [51:0] conf_q[$];
    logic [47:0] cmd_q[$];
    logic [9:0]  done_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: DUT output with no expectation queued", name);
    endtask

    // Monitor: pop and compare on every output handshake / pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (obuf_conf_valid && obuf_conf_ready) begin
                if (conf_q.size() == 0) unexpected("conf_extra");
                else check("conf", {obuf_conf_mode, obuf_conf_trans_num, obuf_conf_mask}, conf_q.pop_front());
            end
            if (ddr_cmd_valid && ddr_cmd_ready) begin
                if (cmd_q.size() == 0) unexpected("cmd_extra");
                else check("cmd", {ddr_cmd_addr, ddr_cmd_len}, cmd_q.pop_front());
            end
            if (tx_done_pulse) begin
                if (done_q.size() == 0) unexpected("done_extra");
                else check("done", {tx_done_opcode, tx_done_buf_id}, done_q.pop_front());
            end
        end
    end

    // Present one instruction for one cycle; returns 1ns into cycle 1
    task automatic send(input logic [3:0] op, input logic [5:0] bid, input logic [11:0] ps,
                        input logic [31:0] addr, input logic [3:0] lt);
        @(posedge clk); #1;
        layer_type = lt;
        ins = '0;
        ins[61:58] = op;
        ins[57:52] = bid;
        ins[51:40] = ps;
        ins[31:0]  = addr;
        ins_valid = 1'b1;
        @(negedge clk);
        check("accept_ready", ins_ready, 1);
        @(posedge clk); #1;
        ins_valid = 1'b0;
        ins = {$urandom, $urandom};
        layer_type = ~lt;
    endtask

    // Wait until conf and cmd have both handshaken (state is XFER)
    task automatic wait_xfer();
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while ((obuf_conf_valid || ddr_cmd_valid) && cyc < 100);
        if (cyc >= 100) unexpected("wait_xfer_timeout");
        @(posedge clk); #1;
    endtask

    // Drive beats until n handshakes; returns 1ns after the final handshake edge
    task automatic run_beats(input int n, input bit toggle);
        int got = 0;
        int cyc = 0;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        while (got < n && cyc < 500) begin
            @(negedge clk);
            check("no_early_pulse", tx_done_pulse, 0);
            if (beat_valid && beat_ready) got++;
            cyc++;
            @(posedge clk); #1;
            if (toggle) beat_ready = ~beat_ready;
        end
        beat_valid = 1'b0;
        beat_ready = 1'b0;
        if (got < n) unexpected("beat_timeout");
    endtask

    task automatic check_pulse_then_idle(input logic [3:0] op, input logic [5:0] bid);
        @(negedge clk);
        check("pulse_after_last_beat", tx_done_pulse, 1);
        check("pulse_ins_ready", ins_ready, 0);
        @(negedge clk);
        check("pulse_one_cycle", tx_done_pulse, 0);
        check("ready_after_pulse", ins_ready, 1);
        check("done_hold", {tx_done_opcode, tx_done_buf_id}, {op, bid});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        errors++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        // Reset state
        #12;
        check("rst_ins_ready", ins_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valids", {obuf_conf_valid, ddr_cmd_valid, tx_done_pulse}, 0);
        check("rst_data", {ddr_cmd_addr, ddr_cmd_len, obuf_conf_mask}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: p_size=8, buf_id=2, per-PE mask, zero-wait handshakes
        conf_q.push_back({4'h1, 16'd8, 32'h0000_0004});
        cmd_q.push_back({32'h0000_1000, 16'd8});
        done_q.push_back({4'h5, 6'd2});
        send(4'h5, 6'd2, 12'd8, 32'h1000, 4'b0001);
        @(negedge clk);
        check("c1_ins_ready", ins_ready, 0);
        check("c1_busy", busy, 1);
        check("c1_valids", {obuf_conf_valid, ddr_cmd_valid}, 2'b11);
        check("c1_mask", obuf_conf_mask, 32'h4);
        @(negedge clk);
        check("c2_valids_done", {obuf_conf_valid, ddr_cmd_valid}, 2'b00);
        check("c2_busy", busy, 1);
        @(posedge clk); #1;
        run_beats(8, 1'b0);
        check_pulse_then_idle(4'h5, 6'd2);

        // 2: nibble mask, conf stalled 5 cycles while cmd accepted at once
        obuf_conf_ready = 1'b0;
        conf_q.push_back({4'h0, 16'd4, 32'h0000_F000});
        cmd_q.push_back({32'h0000_2000, 16'd4});
        done_q.push_back({4'h9, 6'd3});
        send(4'h9, 6'd3, 12'd4, 32'h2000, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_conf_valid", obuf_conf_valid, 1);
            if (i == 0) begin
                check("stall_cmd_valid_c1", ddr_cmd_valid, 1);
                check("done_opcode_held", tx_done_opcode, 4'h5);
            end else begin
                check("stall_cmd_valid_low", ddr_cmd_valid, 0);
            end
        end
        @(posedge clk); #1;
        obuf_conf_ready = 1'b1;
        @(negedge clk);
        check("conf_hs_cycle_valid", obuf_conf_valid, 1);
        @(negedge clk);
        check("after_conf_hs_valid", obuf_conf_valid, 0);
        @(posedge clk); #1;
        run_beats(4, 1'b0);
        check_pulse_then_idle(4'h9, 6'd3);

        // 3: p_size=0 -> pulse at cycle 1, ready at cycle 2, no conf/cmd
        done_q.push_back({4'h3, 6'd7});
        send(4'h3, 6'd7, 12'd0, 32'h3000, 4'b0001);
        @(negedge clk);
        check("zero_pulse_c1", tx_done_pulse, 1);
        check("zero_ins_ready_c1", ins_ready, 0);
        check("zero_no_valids", {obuf_conf_valid, ddr_cmd_valid}, 2'b00);
        @(negedge clk);
        check("zero_ready_c2", ins_ready, 1);
        check("zero_pulse_c2", tx_done_pulse, 0);
        check("zero_done_buf", tx_done_buf_id, 6'd7);

        // 4: beats in IDLE ignored, then p_size=5 with toggling beat_ready
        @(posedge clk); #1;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        beat_valid = 1'b0;
        beat_ready = 1'b0;
        conf_q.push_back({4'h1, 16'd5, 32'h0000_0002});
        cmd_q.push_back({32'h0000_0040, 16'd5});
        done_q.push_back({4'h1, 6'd1});
        send(4'h1, 6'd1, 12'd5, 32'h40, 4'b0001);
        wait_xfer();
        run_beats(5, 1'b1);
        check_pulse_then_idle(4'h1, 6'd1);

        // 5: reset mid-XFER aborts with no pulse
        conf_q.push_back({4'h1, 16'd10, 32'h0000_0001});
        cmd_q.push_back({32'h0000_5000, 16'd10});
        send(4'h6, 6'd0, 12'd10, 32'h5000, 4'b0001);
        wait_xfer();
        run_beats(3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ins_ready", ins_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_outputs", {obuf_conf_valid, ddr_cmd_valid, tx_done_pulse, tx_done_opcode, tx_done_buf_id}, 0);
        check("arst_cmd", {ddr_cmd_addr, ddr_cmd_len}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 6: p_size=40 from address 0 (split into 16/16/8 when enabled)
        conf_q.push_back({4'h1, 16'd40, 32'h0000_0010});
`ifdef TX_BURST_SPLIT_EN
        cmd_q.push_back({32'h0000_0000, 16'd16});
        cmd_q.push_back({32'h0000_0400, 16'd16});
        cmd_q.push_back({32'h0000_0800, 16'd8});
`else
        cmd_q.push_back({32'h0000_0000, 16'd40});
`endif
        done_q.push_back({4'h2, 6'd4});
        send(4'h2, 6'd4, 12'd40, 32'h0, 4'b0001);
        wait_xfer();
        run_beats(40, 1'b0);
        check_pulse_then_idle(4'h2, 6'd4);

        repeat (3) @(negedge clk);
        check("conf_q_drained", conf_q.size(), 0);
        check("cmd_q_drained", cmd_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
